// File: rtl/test_5_invert_arbiter.sv
// test_5_invert_arbiter: round-robin arbiter feeding a one-entry inversion output register (optional TEST_5_INVERT_MASK_EN adds inv_mask_i)
module test_5_invert_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDTH-1:0]         out_vector_o,
  output logic [IW-1:0]            out_id_o,
`ifdef TEST_5_INVERT_MASK_EN
  input  logic [WIDTH-1:0]         inv_mask_i,
`endif
  output logic [7:0]               xfer_cnt_o
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, gnt_id, ptr_d;
  logic found, accept;
  logic [WIDTH-1:0] gnt_data, result;
  int k;
  assign accept = rst_ni && (state == EMPTY || out_ready_i);
  assign out_valid_o = state == FULL;
  assign gnt_data = req_data_i[gnt_id*WIDTH +: WIDTH];
`ifdef TEST_5_INVERT_MASK_EN
  assign result = gnt_data ^ inv_mask_i;
`else
  assign result = ~gnt_data;
`endif
  // round-robin search upward from rr_ptr with wrap; grant only when the output slot can take it
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    k = 0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req_valid_i[k]) begin
        found = 1'b1;
        gnt_id = IW'(k);
      end
    end
    if (accept && found) req_ready_o[gnt_id] = 1'b1;
    ptr_d = gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    state_d = accept ? (found ? FULL : EMPTY) : state;
  end
  // state, result register, pointer and transfer counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= EMPTY;
      out_vector_o <= '0;
      out_id_o <= '0;
      rr_ptr <= '0;
      xfer_cnt_o <= '0;
    end else begin
      state <= state_d;
      if (out_valid_o && out_ready_i) xfer_cnt_o <= xfer_cnt_o + 8'd1;
      if (accept && found) begin
        out_vector_o <= result;
        out_id_o <= gnt_id;
        rr_ptr <= ptr_d;
      end
    end
  end
endmodule

// File: tb/tb_test_5_invert_arbiter.sv
// tb_test_5_invert_arbiter: directed table and corner sequences for test_5_invert_arbiter
module tb_test_5_invert_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [3:0] req_valid_i = 4'b0;
  logic [15:0] req_data_i = {4'hC, 4'hA, 4'h2, 4'h1};
  logic out_ready_i = 1'b0;
  logic [3:0] req_ready_o;
  logic out_valid_o;
  logic [3:0] out_vector_o;
  logic [1:0] out_id_o;
  logic [7:0] xfer_cnt_o;
`ifdef TEST_5_INVERT_MASK_EN
  logic [3:0] inv_mask_i = 4'hF;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [3:0] v;
    logic r;
    logic [3:0] rr;
    logic ov;
    logic [3:0] vec;
    logic [1:0] id;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[13];
  logic [3:0] inv_of_id[4];

  test_5_invert_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_vector_o(out_vector_o),
    .out_id_o(out_id_o),
`ifdef TEST_5_INVERT_MASK_EN
    .inv_mask_i(inv_mask_i),
`endif
    .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic outs(input string tag, input int rr, input int ov, input int vec, input int id, input int cnt);
    chk({tag, " req_ready"}, int'(req_ready_o), rr);
    chk({tag, " out_valid"}, int'(out_valid_o), ov);
    chk({tag, " out_vector"}, int'(out_vector_o), vec);
    chk({tag, " out_id"}, int'(out_id_o), id);
    chk({tag, " xfer_cnt"}, int'(xfer_cnt_o), cnt);
  endtask

  initial begin
    inv_of_id = '{4'hE, 4'hD, 4'h5, 4'h3};
    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 4'h0, 2'd0, 8'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'h5, 2'd2, 8'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 4'h5, 2'd2, 8'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'h3, 2'd3, 8'd1};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 4'hE, 2'd0, 8'd2};
    tbl[5]  = '{4'b0011, 1'b0, 4'b0000, 1'b1, 4'hE, 2'd0, 8'd2};
    tbl[6]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, 4'hE, 2'd0, 8'd2};
    tbl[7]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 4'hD, 2'd1, 8'd3};
    tbl[8]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'hE, 2'd0, 8'd4};
    tbl[9]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'hD, 2'd1, 8'd5};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 4'h3, 2'd3, 8'd6};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'h3, 2'd3, 8'd6};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'h3, 2'd3, 8'd7};
    req_valid_i = 4'b1111;
    out_ready_i = 1'b1;
    #1;
    outs("reset", 0, 0, 0, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 13; i++) begin
      req_valid_i = tbl[i].v;
      out_ready_i = tbl[i].r;
      #1;
      outs($sformatf("vec%0d", i), tbl[i].rr, tbl[i].ov, tbl[i].vec, tbl[i].id, tbl[i].cnt);
      @(negedge clk_i);
    end
    req_valid_i = 4'b0100;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("pre-reset full", int'(out_valid_o), 1);
    #2;
    rst_ni = 1'b0;
    #1;
    outs("async reset", 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_valid_i = 4'b1111;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      outs($sformatf("fair%0d", i), 1 << (i % 4), i > 0 ? 1 : 0,
           i > 0 ? int'(inv_of_id[(i - 1) % 4]) : 0, i > 0 ? (i - 1) % 4 : 0, i > 1 ? i - 1 : 0);
      @(negedge clk_i);
    end
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      outs($sformatf("stall%0d", i), 0, 1, 4'hE, 0, 4);
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    #1;
    outs("release", 4'b0010, 1, 4'hE, 0, 4);
    @(negedge clk_i);
    #1;
    outs("after release", 4'b0100, 1, 4'hD, 1, 5);
    for (int i = 0; i < 250; i++) @(negedge clk_i);
    #1;
    chk("cnt 255", int'(xfer_cnt_o), 255);
    @(negedge clk_i);
    #1;
    chk("cnt wrap", int'(xfer_cnt_o), 0);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    req_data_i = 16'h0000;
    req_valid_i = 4'b0001;
`ifdef TEST_5_INVERT_MASK_EN
    inv_mask_i = 4'b0011;
`endif
    #1;
    chk("mask grant", int'(req_ready_o), 4'b0001);
    @(negedge clk_i);
    #1;
`ifdef TEST_5_INVERT_MASK_EN
    outs("mask", 4'b0001, 1, 4'b0011, 0, 0);
`else
    outs("mask", 4'b0001, 1, 4'b1111, 0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/test_5_invert_arbiter.md
TEST_5_INVERT_ARBITER -- requirements
Module: test_5_invert_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the inversion lane (range 2..8).
REQ-002 Parameter WIDTH, default 4, SHALL set the bit width of each data vector.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid_i  input  NUM_REQ  SHALL carry the per-requester valid flags.
REQ-006 req_data_i  input  NUM_REQ*WIDTH  SHALL carry the request vectors; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-007 req_ready_o  output  NUM_REQ  SHALL be one-hot or zero, marking the requester accepted this cycle.
REQ-008 out_valid_o  output  1  SHALL flag a valid result.
REQ-009 out_ready_i  input  1  SHALL be downstream acceptance.
REQ-010 out_vector_o  output  WIDTH  SHALL be the per-bit inverted data of the granted request.
REQ-011 out_id_o  output  clog2(NUM_REQ)  SHALL be the index of the requester that produced out_vector_o.
REQ-012 xfer_cnt_o  output  8  SHALL count completed output transfers.

Function
REQ-013 The block SHALL hold a one-entry output register and a two-state FSM: EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
REQ-014 The accept condition SHALL be: state EMPTY, or state FULL with out_ready_i=1.
REQ-015 When accept holds and any req_valid_i bit is set, req_ready_o SHALL assert combinationally for exactly one requester, chosen round-robin starting at pointer rr_ptr and searching upward with wrap from NUM_REQ-1 to 0.
REQ-016 On an accept with requester g granted, the next edge SHALL load out_vector_o = ~req_data_i[g], out_id_o = g, state FULL, rr_ptr = (g+1) mod NUM_REQ.
REQ-017 Latency from accepted request to out_valid_o SHALL be one cycle; throughput SHALL be one result per cycle while out_ready_i=1.
REQ-018 In FULL with out_ready_i=0, req_ready_o SHALL be zero and out_vector_o/out_id_o SHALL remain stable.
REQ-019 In FULL with out_ready_i=1 and no req_valid_i set, the next state SHALL be EMPTY.
REQ-020 rr_ptr SHALL change only on a grant.
REQ-021 xfer_cnt_o SHALL increment by 1 on each cycle with out_valid_o=1 and out_ready_i=1, wrapping 255 -> 0.
REQ-022 req_valid_i changes while ungranted SHALL have no side effect; a requester deasserting before grant is simply skipped.

Reset
REQ-023 While rst_ni=0: state EMPTY, out_valid_o=0, out_vector_o=0, out_id_o=0, rr_ptr=0, xfer_cnt_o=0, req_ready_o=0, applied asynchronously.
REQ-024 Reset asserted while FULL SHALL discard the held result with no transfer counted; the first grant after reset release SHALL search from requester 0.

Configuration
REQ-025 With macro TEST_5_INVERT_MASK_EN defined, the block SHALL add input inv_mask_i (WIDTH bits), sampled on the accept edge; bit b of the result is inverted only where inv_mask_i[b]=1, else passed through.
REQ-026 Without TEST_5_INVERT_MASK_EN, inv_mask_i SHALL not exist and all bits SHALL be inverted.

Verification
REQ-027 Reset check: rst_ni low mid-run with out_valid_o=1 -> all outputs 0 asynchronously, xfer_cnt_o=0, next grant goes to requester 0.
REQ-028 Single request: req_valid_i=4'b0100, data[2]=4'b1010, out_ready_i=1 -> req_ready_o=4'b0100, next cycle out_valid_o=1, out_vector_o=4'b0101, out_id_o=2.
REQ-029 Fairness: req_valid_i=4'b1111 held, out_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, xfer_cnt_o increments each cycle.
REQ-030 Backpressure: FULL, out_ready_i=0 for 5 cycles -> req_ready_o=0, outputs stable; release -> transfer counted once, next grant same cycle.
REQ-031 Counter wrap: 256 transfers -> xfer_cnt_o returns to 0.
REQ-032 Mask (macro defined): inv_mask_i=4'b0011, data=4'b0000 -> out_vector_o=4'b0011; macro undefined -> 4'b1111.
